// File: rtl/lgn_mnist.sv
`default_nettype none
// ============================================================================
// Module      : lgn_mnist
// Description : Logic-gate-network classifier for 16x16 binary images. A
//               32-byte stream is framed into a 256-pixel image; 320 fixed
//               two-input gates vote for 10 classes and the argmax class
//               (lowest index on ties) is presented one cycle after the
//               last byte of each frame.
// Options     : LGN_MNIST_SCORE_OUT_EN - when defined, the winning score is
//               registered and driven on uo_out; otherwise uo_out is 8'h00.
// Revision    : 1.0 - initial release
// ============================================================================
module lgn_mnist (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int NUM_GATES    = 320;
    localparam int NUM_CLASSES  = 10;
    localparam int GATES_PER_CL = NUM_GATES / NUM_CLASSES;
    localparam int IMG_BITS     = 256;
    localparam int ADDR_MUL_A   = 37;
    localparam int ADDR_OFF_A   = 11;
    localparam int ADDR_MUL_B   = 101;
    localparam int ADDR_OFF_B   = 59;
    localparam logic [4:0] LAST_BYTE = 5'd31;
    localparam logic [7:0] OE_MASK   = 8'h0F;

    // Frame capture state
    logic [4:0]          byte_cnt;
    logic [IMG_BITS-1:0] image;
    logic                frame_done;   // last byte of a frame was captured on the previous enabled edge

    // Classifier datapath
    logic [NUM_GATES-1:0] gate_out;
    logic [5:0]           class_score [NUM_CLASSES];
    logic [3:0]           best_idx;
    logic [5:0]           best_score;

    // Result registers
    logic [3:0] win_idx;
    logic       hold;
    logic       result_upd;

    assign hold       = uio_in[7];
    assign result_upd = ena & frame_done & ~hold;

    // Lower uio_in bits carry no function
    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in[6:0]};

    // Byte counter, image shift-in and end-of-frame flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt   <= '0;
            image      <= '0;
            frame_done <= 1'b0;
        end else if (ena) begin
            image[{byte_cnt, 3'b000} +: 8] <= ui_in;
            byte_cnt   <= byte_cnt + 5'd1;
            frame_done <= (byte_cnt == LAST_BYTE);
        end
    end

    // Fixed gate network: pixel taps and operator are elaborated per gate
    for (genvar k = 0; k < NUM_GATES; k++) begin : g_gate
        localparam int IDX_A = (ADDR_MUL_A * k + ADDR_OFF_A) % IMG_BITS;
        localparam int IDX_B = (ADDR_MUL_B * k + ADDR_OFF_B) % IMG_BITS;
        if ((k % 4) == 0) begin : g_and
            assign gate_out[k] = image[IDX_A] & image[IDX_B];
        end else if ((k % 4) == 1) begin : g_or
            assign gate_out[k] = image[IDX_A] | image[IDX_B];
        end else if ((k % 4) == 2) begin : g_xor
            assign gate_out[k] = image[IDX_A] ^ image[IDX_B];
        end else begin : g_nand
            assign gate_out[k] = ~(image[IDX_A] & image[IDX_B]);
        end
    end

    // Popcount per class: class c owns gates c, c+10, c+20, ...
    always_comb begin
        for (int c = 0; c < NUM_CLASSES; c++) begin
            class_score[c] = '0;
            for (int j = 0; j < GATES_PER_CL; j++) begin
                class_score[c] = class_score[c] + {5'b00000, gate_out[c + NUM_CLASSES * j]};
            end
        end
    end

    // Argmax with strict compare so the lowest class wins ties
    always_comb begin
        best_idx   = '0;
        best_score = class_score[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (class_score[c] > best_score) begin
                best_idx   = 4'(c);
                best_score = class_score[c];
            end
        end
    end

    // Winning index register, updated once per completed frame unless held
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_idx <= '0;
        end else if (result_upd) begin
            win_idx <= best_idx;
        end
    end

`ifdef LGN_MNIST_SCORE_OUT_EN
    logic [5:0] win_score;

    // Winning score register, updated alongside the index
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_score <= '0;
        end else if (result_upd) begin
            win_score <= best_score;
        end
    end

    assign uo_out = {2'b00, win_score};
`else
    assign uo_out = 8'h00;
`endif

    assign uio_out = {4'b0000, win_idx};
    assign uio_oe  = OE_MASK;

endmodule
`default_nettype wire

// File: tb/tb_lgn_mnist.sv
`default_nettype none
// ============================================================================
// Module      : tb_lgn_mnist
// Description : Scoreboard bench for lgn_mnist. The stimulus side tracks the
//               frame protocol and pushes the result expected after each
//               edge; a monitor pops and compares on every falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lgn_mnist;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    lgn_mnist dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    typedef struct {
        int         tag;
        logic [3:0] idx;
        logic [5:0] sc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    int         n_checks;
    int         n_err;
    int         edge_cnt;
    logic       mon_en;

    // Bench-side protocol model
    logic [255:0] m_img;
    logic [4:0]   m_b;
    logic         m_done;
    logic [7:0]   frame_buf [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to tag expectations
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [7:0] exp_uo(input logic [5:0] sc);
`ifdef LGN_MNIST_SCORE_OUT_EN
        return {2'b00, sc};
`else
        return 8'h00;
`endif
    endfunction

    // Reference classifier computed straight from the gate definitions
    function automatic logic [9:0] model(input logic [255:0] img);
        int   s [10];
        int   a;
        int   b;
        int   bi;
        logic x;
        logic y;
        logic g;
        for (int c = 0; c < 10; c++) s[c] = 0;
        for (int k = 0; k < 320; k++) begin
            a = (37 * k + 11) % 256;
            b = (101 * k + 59) % 256;
            x = img[a];
            y = img[b];
            case (k % 4)
                0:       g = x & y;
                1:       g = x | y;
                2:       g = x ^ y;
                default: g = ~(x & y);
            endcase
            if (g) s[k % 10] = s[k % 10] + 1;
        end
        bi = 0;
        for (int c = 1; c < 10; c++) if (s[c] > s[bi]) bi = c;
        return {4'(bi), 6'(s[bi])};
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic push(input logic [3:0] idx, input logic [5:0] sc);
        exp_t e;
        e.tag = edge_cnt;
        e.idx = idx;
        e.sc  = sc;
        exp_q.push_back(e);
    endtask

    // One clock edge with the given inputs; the model follows the same edge
    task automatic tick(input logic [7:0] d, input logic e, input logic h, input logic r);
        logic [9:0] res;
        ui_in  = d;
        ena    = e;
        uio_in = {h, 7'h2A};
        rst_n  = r;
        @(posedge clk);
        #1;
        if (!r) begin
            m_b    = '0;
            m_done = 1'b0;
            m_img  = '0;
            push(4'd0, 6'd0);
        end else if (e) begin
            if (m_done && !h) begin
                res = model(m_img);
                push(res[9:6], res[5:0]);
            end
            m_done = (m_b == 5'd31);
            m_img[{m_b, 3'b000} +: 8] = d;
            m_b = m_b + 5'd1;
        end
    endtask

    // Send frame_buf; optional ena=0 stall before byte stall_at; optional
    // direct check of the previous frame's result after the first byte
    task automatic send_frame(input logic h_first, input logic h_rest, input int stall_at,
                              input logic do_chk, input logic [3:0] ci, input logic [5:0] cs,
                              input string nm);
        for (int i = 0; i < 32; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < 5; s++) tick(8'(s * 90) ^ 8'hC3, 1'b0, h_rest, 1'b1);
            end
            tick(frame_buf[i], 1'b1, (i == 0) ? h_first : h_rest, 1'b1);
            if (i == 0 && do_chk) begin
                check({nm, "_idx"}, uio_out, {4'h0, ci});
                check({nm, "_score"}, uo_out, exp_uo(cs));
            end
        end
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < 32; i++) frame_buf[i] = v;
    endtask

    // Monitor: adopt expectations that have become due, then compare
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].tag <= edge_cnt) cur = exp_q.pop_front();
            check("mon_idx", uio_out, {4'h0, cur.idx});
            check("mon_score", uo_out, exp_uo(cur.sc));
            check("mon_oe", uio_oe, 8'h0F);
        end
    end

    initial begin
        logic [9:0] res_b;
        n_checks = 0;
        n_err    = 0;
        edge_cnt = 0;
        mon_en   = 1'b0;
        cur.tag  = 0;
        cur.idx  = '0;
        cur.sc   = '0;
        m_img    = '0;
        m_b      = '0;
        m_done   = 1'b0;
        rst_n    = 1'b0;
        ena      = 1'b0;
        ui_in    = 8'h00;
        uio_in   = 8'h00;

        // Reset with ena and HOLD asserted: reset must still win
        tick(8'hFF, 1'b1, 1'b1, 1'b0);
        mon_en = 1'b1;
        tick(8'hFF, 1'b1, 1'b1, 1'b0);
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'h0F);

        // All-zero frame: odd classes 16, even 0 -> class 1, score 16
        fill_const(8'h00);
        send_frame(1'b0, 1'b0, -1, 1'b0, 4'd0, 6'd0, "none");
        // All-ones frame; first byte exposes the zero-frame result
        fill_const(8'hFF);
        send_frame(1'b0, 1'b0, -1, 1'b1, 4'd1, 6'd16, "zeros_frame");
        // Zero frame after ones: 0/16 holds for the whole frame, then 1/16
        fill_const(8'h00);
        send_frame(1'b0, 1'b0, -1, 1'b1, 4'd0, 6'd16, "ones_frame");

        // Mixed directed patterns checked against the reference classifier
        for (int i = 0; i < 32; i++) frame_buf[i] = 8'(i * 37 + 5);
        send_frame(1'b0, 1'b0, -1, 1'b1, 4'd1, 6'd16, "zeros_after_ones");
        for (int i = 0; i < 32; i++) frame_buf[i] = (i % 2 == 0) ? 8'hAA : 8'h55;
        send_frame(1'b0, 1'b0, -1, 1'b0, 4'd0, 6'd0, "none");
        fill_const(8'h00);
        frame_buf[5]  = 8'h10;
        frame_buf[20] = 8'h81;
        send_frame(1'b0, 1'b0, -1, 1'b0, 4'd0, 6'd0, "none");

        // Partial ones frame discarded by a mid-frame reset
        for (int i = 0; i < 10; i++) tick(8'hFF, 1'b1, 1'b0, 1'b1);
        tick(8'hFF, 1'b1, 1'b0, 1'b0);
        check("midreset_idx", uio_out, 8'h00);
        fill_const(8'h00);
        send_frame(1'b0, 1'b0, -1, 1'b0, 4'd0, 6'd0, "none");
        fill_const(8'hFF);
        send_frame(1'b0, 1'b0, -1, 1'b1, 4'd1, 6'd16, "after_mid_reset");

        // Stalled frame with junk on ui_in during ena=0
        for (int i = 0; i < 32; i++) frame_buf[i] = 8'(i * 37 + 5);
        send_frame(1'b0, 1'b0, 13, 1'b0, 4'd0, 6'd0, "none");
        // Pattern B frame; its first edge publishes the stalled-frame result
        for (int i = 0; i < 32; i++) frame_buf[i] = 8'(8'hF0 ^ 8'(i * 11));
        res_b = model(m_img);
        send_frame(1'b0, 1'b0, -1, 1'b1, res_b[9:6], res_b[5:0], "stall_frame");

        // HOLD across a frame boundary keeps the previous result
        res_b = model(m_img);
        fill_const(8'h00);
        send_frame(1'b0, 1'b0, -1, 1'b0, 4'd0, 6'd0, "none");
        fill_const(8'hFF);
        send_frame(1'b1, 1'b1, -1, 1'b1, res_b[9:6], res_b[5:0], "hold_retain");
        fill_const(8'h00);
        send_frame(1'b0, 1'b0, -1, 1'b1, 4'd0, 6'd16, "after_hold");

        for (int i = 0; i < 4; i++) tick(8'h00, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lgn_mnist.md
LGN_MNIST -- requirements
Module: lgn_mnist

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk is the only clock; rst_n is sampled on posedge clk, and 0 resets.
REQ-002 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 Port ena, input, 1 bit: 1 = advance; 0 = hold all state (reset still applies).
REQ-005 Port ui_in, input, 8 bits: image byte stream, one byte per enabled cycle.
REQ-006 Port uio_in, input, 8 bits: bit 7 = HOLD (freeze results); bits 6:0 ignored.
REQ-007 Port uo_out, output, 8 bits: winning class score (zero-extended).
REQ-008 Port uio_out, output, 8 bits: [3:0] winning class index 0-9; [7:4] = 0.
REQ-009 Port uio_oe, output, 8 bits: constant 8'h0F.

Function
REQ-010 SHALL frame input as 16x16 binary image = 32 bytes; 5-bit byte counter B starts at 0 after reset, +1 per enabled cycle, and wraps 31->0 with no gap.
REQ-011 SHALL store ui_in bit i at byte B as pixel P[8*B+i] in a 256-bit image register.
REQ-012 SHALL define 320 gates k=0..319: a=(37k+11) mod 256, b=(101k+59) mod 256, x=P[a], y=P[b].
REQ-013 SHALL select each gate's op by k mod 4: 0 = x AND y, 1 = x OR y, 2 = x XOR y, 3 = NOT(x AND y).
REQ-014 SHALL compute score S[c], c=0..9, as the count of gates with k mod 10 == c that output 1; each score is 0..32 and 6 bits wide.
REQ-015 SHALL take winner = argmax S[c]; ties go to the lowest c.
REQ-016 SHALL evaluate gates on the full image including byte 31 as captured on the same edge; index/score registers update on the first enabled edge after byte 31 is captured (1-cycle latency).
REQ-017 SHALL hold both results constant for 32 enabled cycles, until the next frame completes.
REQ-018 SHALL skip the result update when HOLD=1 at the update edge; frame capture continues.
REQ-019 SHALL freeze B, the image register and the results when ena=0.
REQ-020 SHALL NOT output results for a partial frame; reset mid-frame discards captured bytes, and the next byte is byte 0.

Reset
REQ-021 SHALL on rst_n=0 at posedge clk set B=0, image register=0, index=0 and score=0, so uo_out=0 and uio_out=0.
REQ-022 SHALL keep uio_oe at 8'h0F during and after reset.
REQ-023 SHALL give reset priority over ena and HOLD.

Configuration
REQ-024 Macro LGN_MNIST_SCORE_OUT_EN defined: uo_out = {2'b00, winning score}.
REQ-025 Macro LGN_MNIST_SCORE_OUT_EN undefined: uo_out is constant 8'h00 and no score register exists; index behaviour is unchanged.

Verification
REQ-026 Reset, then 32 bytes of 8'h00, ena=1 -> one cycle after byte 31: uio_out[3:0]=1 and uo_out=16 (odd classes 16, even classes 0).
REQ-027 32 bytes of 8'hFF -> all classes score 16 -> index 0, uo_out=16.
REQ-028 Frame of 8'hFF, then a frame of 8'h00 -> results read 0/16 for the 32 cycles before switching to 1/16; no intermediate values.
REQ-029 Reset after 10 bytes of 8'hFF, then 32 bytes of 8'h00 -> index 1, score 16; earlier bytes have no effect.
REQ-030 ena=0 for 5 cycles mid-frame with ui_in toggling -> B and results unchanged; the frame result equals that of the same 32 bytes with no stall.
REQ-031 HOLD=1 across a frame boundary -> the previous result is retained; with the macro undefined, uo_out=0 in every scenario.
